// File: rtl/debounce_scan_arbiter.sv
// debounce_scan_arbiter: one shared debounce timer, round-robin granted to switch channels
// Ports: clk, rst (async, active-high); sw_in raw levels; sw_out debounced levels;
//        sw_rise/sw_fall one-cycle edge pulses (only with DEBOUNCE_SCAN_EDGE_EN defined);
//        busy while the engine is counting or committing; grant_id owning channel.
module debounce_scan_arbiter #(
   parameter int NUM_SW          = 4,
   parameter int DEBOUNCE_PERIOD = 30,
   parameter int CNT_W           = 16,
   parameter int ID_W            = $clog2(NUM_SW)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_SW-1:0] sw_in,
   output logic [NUM_SW-1:0] sw_out,
`ifdef DEBOUNCE_SCAN_EDGE_EN
   output logic [NUM_SW-1:0] sw_rise,
   output logic [NUM_SW-1:0] sw_fall,
`endif
   output logic              busy,
   output logic [ID_W-1:0]   grant_id
);
   localparam logic [1:0] IDLE = 2'd0, COUNT = 2'd1, COMMIT = 2'd2;
   localparam logic [ID_W-1:0] LAST = ID_W'(NUM_SW - 1);
   localparam logic [ID_W:0] NSW = (ID_W + 1)'(NUM_SW);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_PERIOD - 1);
   logic [NUM_SW-1:0] sync1_q, sync2_q, sw_out_q, sw_out_d, req;
   logic [1:0] state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ID_W-1:0] rr_q, rr_d, gid_q, gid_d, off, pick, nxt;
   logic [2*NUM_SW-1:0] rot;
   logic [ID_W:0] sum;
   logic found;
`ifdef DEBOUNCE_SCAN_EDGE_EN
   logic [NUM_SW-1:0] rise_q, rise_d, fall_q, fall_d;
`endif
   assign req = sync2_q ^ sw_out_q;
   // rotate so bit 0 is the channel at rr_q; first set bit is the winner
   assign rot = {req, req} >> rr_q;
   assign nxt = gid_q == LAST ? '0 : gid_q + 1'b1;
   always_comb begin
      found = 1'b0;
      off = '0;
      for (int k = 0; k < NUM_SW; k++)
         if (!found && rot[k]) begin
            found = 1'b1;
            off = ID_W'(k);
         end
      sum = {1'b0, rr_q} + {1'b0, off};
      pick = sum >= NSW ? ID_W'(sum - NSW) : sum[ID_W-1:0];
   end
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      rr_d = rr_q;
      gid_d = gid_q;
      sw_out_d = sw_out_q;
`ifdef DEBOUNCE_SCAN_EDGE_EN
      rise_d = '0;
      fall_d = '0;
`endif
      if (state_q == IDLE) begin
         if (found) begin
            gid_d = pick;
            cnt_d = '0;
            state_d = COUNT;
         end
      end else if (state_q == COUNT) begin
         if (!req[gid_q]) begin
            state_d = IDLE;
            cnt_d = '0;
            rr_d = nxt;
         end else if (cnt_q == CNT_MAX) state_d = COMMIT;
         else cnt_d = cnt_q + 1'b1;
      end else if (state_q == COMMIT) begin
         sw_out_d[gid_q] = sync2_q[gid_q];
`ifdef DEBOUNCE_SCAN_EDGE_EN
         // gated by req so a bounce during the commit cycle emits no false edge
         rise_d[gid_q] = req[gid_q] & sync2_q[gid_q];
         fall_d[gid_q] = req[gid_q] & ~sync2_q[gid_q];
`endif
         rr_d = nxt;
         state_d = IDLE;
      end else state_d = IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         sw_out_q <= '0;
         state_q <= IDLE;
         cnt_q <= '0;
         rr_q <= '0;
         gid_q <= '0;
`ifdef DEBOUNCE_SCAN_EDGE_EN
         rise_q <= '0;
         fall_q <= '0;
`endif
      end else begin
         sync1_q <= sw_in;
         sync2_q <= sync1_q;
         sw_out_q <= sw_out_d;
         state_q <= state_d;
         cnt_q <= cnt_d;
         rr_q <= rr_d;
         gid_q <= gid_d;
`ifdef DEBOUNCE_SCAN_EDGE_EN
         rise_q <= rise_d;
         fall_q <= fall_d;
`endif
      end
   end
   assign sw_out = sw_out_q;
   assign busy = state_q == COUNT || state_q == COMMIT;
   assign grant_id = gid_q;
`ifdef DEBOUNCE_SCAN_EDGE_EN
   assign sw_rise = rise_q;
   assign sw_fall = fall_q;
`endif
endmodule

// File: doc/debounce_scan_arbiter.md
# debounce_scan_arbiter

Shares one debounce timing engine among NUM_SW raw mechanical switch inputs. Each channel is synchronized with two flops and raises a request whenever its synchronized level differs from its debounced output. A round-robin arbiter grants the engine to one requester at a time. The engine commits the new level only after DEBOUNCE_PERIOD consecutive stable cycles, and aborts on any bounce. The block sits between board-level switch pins and the control logic that consumes clean levels and edge events.

## Interface
- NUM_SW, default 4: number of switch channels, 2..16.
- DEBOUNCE_PERIOD, default 30: required stable cycles, >= 1.
- CNT_W, default 16: timer width; must satisfy 2^CNT_W > DEBOUNCE_PERIOD-1.
- ID_W, default $clog2(NUM_SW): width of grant_id.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- sw_in  in  NUM_SW  raw switch levels, asynchronous.
- sw_out  out  NUM_SW  debounced levels.
- sw_rise  out  NUM_SW  1-cycle pulse when sw_out[i] goes 0->1 (DEBOUNCE_SCAN_EDGE_EN only).
- sw_fall  out  NUM_SW  1-cycle pulse when sw_out[i] goes 1->0 (DEBOUNCE_SCAN_EDGE_EN only).
- busy  out  1  high while the state is COUNT or COMMIT.
- grant_id  out  ID_W  channel currently owning the engine; holds its last value when idle.

## Operation
- Synchronizer: per channel, sync1 <= sw_in and sync2 <= sync1. Reset value is 0.
- Request: req[i] = sync2[i] != sw_out[i]. It is a level, re-evaluated every cycle, and never latched.
- FSM states:
  - IDLE: if any req[i] is set, grant the first set bit found scanning from rr_ptr upward modulo NUM_SW. Load grant_id, clear the counter, and move to COUNT.
  - COUNT: if sync2[g] == sw_out[g], the input bounced back. Go to IDLE, clear the counter, and set rr_ptr = g+1 mod NUM_SW. Otherwise, if counter == DEBOUNCE_PERIOD-1, go to COMMIT. Otherwise increment the counter.
  - COMMIT: sw_out[g] <= sync2[g]. Pulse sw_rise[g] or sw_fall[g] for this one cycle, registered on the same edge as sw_out. Set rr_ptr = g+1 mod NUM_SW and go to IDLE.
- Non-granted channels are ignored during COUNT/COMMIT. A non-granted request that disappears before its grant leaves no trace.
- Only one sw_out bit changes per commit. At most one edge pulse is high in any cycle.
- The counter never exceeds DEBOUNCE_PERIOD-1, so no wrap can occur.

## Timing
- Reset (async assert, any state): state=IDLE, counter=0, rr_ptr=0, grant_id=0, busy=0, sync=0, sw_out=0, sw_rise=sw_fall=0.
- Latency with the engine idle and a clean change first sampled at edge E0:
  - sync2 updates at E1.
  - State is COUNT at E2.
  - State is COMMIT at E(P+2).
  - sw_out and the edge pulse update at E(P+3), i.e. 33 edges for P=30.
- Back-to-back grants: IDLE lasts exactly one cycle between grants. A queued channel's output follows the previous commit by P+2 edges.
- Worst-case wait for a continuously stable requester: (NUM_SW-1)*(P+2) cycles before its grant.
- Abort costs one IDLE cycle. The aborted channel goes to the back of the round-robin order.
- Simultaneous requests resolve purely by rr_ptr. There is no fixed priority.

## Configuration
- DEBOUNCE_SCAN_EDGE_EN defined: the sw_rise and sw_fall ports and their registers exist and behave as above.
- DEBOUNCE_SCAN_EDGE_EN undefined: the ports and registers are omitted. sw_out, busy, and grant_id timing is identical.

## Test plan
- Reset: assert rst mid-COUNT with sw_in=4'b0010 -> all outputs 0 immediately. After release, the engine restarts from IDLE, and sw_out[1] rises 33 edges after the first sampling edge post-reset.
- Clean press ch1, P=30: sw_in[1] 0->1 and held -> busy=1 and grant_id=1 from E2. sw_out[1]=1 and sw_rise[1] pulse exactly at E33 for one cycle.
- Bounce on ch0: high for 10 cycles, then low -> abort. busy drops, sw_out stays 0, no edge pulse, rr_ptr=1.
- Simultaneous ch0 and ch2 press at E0, rr_ptr=0 -> sw_out[0] rises at E33 and sw_out[2] rises at E65.
- Fairness: after ch0 commits (rr_ptr=1), ch0 release and ch3 press arrive together -> ch3 commits first, ch0 falls P+2 edges later with a sw_fall[0] pulse.
- Non-granted glitch: while ch1 is in COUNT, ch2 pulses high for 5 cycles and returns -> ch2 is never granted, and sw_out[2] stays 0.
